stage_mem: RTL
==============

// Module: stage_MEM
// PURPOSE
//  MEM stage plus MEM/WB pipeline register of the RISC-TOY pipeline; sits between EX/MEM and stage_WB.
//  Issues loads/stores to data memory over a req/ack handshake and stalls the pipeline while an access is outstanding.
//  Registers ALU result, load data, PC, ResultSrc and writeback control for stage_WB.
// PARAMETERS
//  TIMEOUT_CYCLES  default 16  max cycles in BUSY before a bus error (used only with DMEM_TIMEOUT_EN)
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  valid_MEM       in   1   instruction in MEM stage is valid
//  flush_MEM       in   1   kill instruction currently in MEM (from hazard unit)
//  MemRead_MEM     in   1   load
//  MemWrite_MEM    in   1   store
//  RegWrite_MEM    in   1   instruction writes rd
//  ResultSrc_MEM   in   2   00 ALU, 01 load, 10 PC, 11 PC+4
//  Rd_MEM          in   5   destination register
//  ALU_result_MEM  in   32  ALU result / memory address
//  WriteData_MEM   in   32  store data
//  PC_MEM          in   32  instruction PC
//  dmem_req        out  1   memory request
//  dmem_we         out  1   1 = write
//  dmem_addr       out  32  word address = ALU_result_MEM
//  dmem_wdata      out  32  store data
//  dmem_ack        in   1   memory completes request this cycle; dmem_rdata valid when !dmem_we
//  dmem_rdata      in   32  load data
//  stall_MEM       out  1   freeze IF..MEM stage registers this cycle
//  RegWrite_WB     out  1   registered; 0 = bubble
//  ResultSrc_WB    out  2   registered
//  Rd_WB           out  5   registered
//  ALU_result_WB   out  32  registered
//  ReadData_MEM    out  32  registered load data (0 for non-loads)
//  PC_WB           out  32  registered
//  bus_err_WB      out  1   registered; 1-cycle pulse when access timed out
// BEHAVIOUR
//  - mem_op = valid_MEM & (MemRead_MEM | MemWrite_MEM).
//  - FSM states: IDLE, BUSY. Reset -> IDLE; all registered outputs reset to 0.
//  - IDLE, mem_op & !flush_MEM: dmem_req=1 combinationally, dmem_we=MemWrite_MEM.
//    On dmem_ack the same cycle, complete; otherwise go BUSY with stall_MEM=1.
//  - BUSY: hold dmem_req=1 and its address/data/we from EX/MEM, which are frozen by the stall.
//    On dmem_ack: complete and return to IDLE; stall_MEM=0 in the ack cycle.
//  - stall_MEM = dmem_req & !dmem_ack. It is combinational, with zero-wait memory giving no stall.
//  - Completion/non-mem op: on the clock edge with stall_MEM=0, MEM/WB latches the inputs.
//    RegWrite_WB = RegWrite_MEM & valid_MEM & !flush_MEM.
//    ReadData_MEM = dmem_rdata for a load, else 0.
//  - While stall_MEM=1, MEM/WB loads a bubble: RegWrite_WB=0, other fields hold.
//  - flush_MEM in IDLE: no dmem_req; bubble into WB.
//  - flush_MEM in BUSY: the access cannot be aborted. Keep req until ack, then write a bubble (RegWrite_WB=0).
//  - Non-mem op: dmem_req=0 and latency is 1 cycle to WB.
//  - A load that acks in cycle N has ReadData_MEM valid from cycle N+1.
//  - dmem_ack while dmem_req=0 is ignored.
//  - Async reset mid-BUSY: return to IDLE and drop dmem_req immediately; memory must tolerate it.
// CONFIGURATION
//  - DMEM_TIMEOUT_EN defined:
//    - A counter runs in BUSY. When it reaches TIMEOUT_CYCLES without ack, force completion and drop req.
//    - In that completion: RegWrite_WB=0, ReadData_MEM=0, bus_err_WB=1 for one cycle.
//  - DMEM_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, bus_err_WB tied 0.
// TESTING
//  1. ALU op (ResultSrc 00, ALU_result=0x1234, Rd=5, RegWrite=1) -> next cycle ALU_result_WB=0x1234, Rd_WB=5, RegWrite_WB=1, no req/stall.
//  2. Load addr 0x40 with ack same cycle, rdata=0xDEADBEEF -> stall never 1; next cycle ReadData_MEM=0xDEADBEEF, ResultSrc_WB=01.
//  3. Store addr 0x80, data 0xA5A5A5A5, ack after 3 cycles -> req/we held with stable addr/data, stall=1 for 3 cycles, WB bubbles, then RegWrite_WB=0.
//  4. Load with flush_MEM asserted in BUSY, ack 2 cycles later -> req held until ack; WB gets bubble (RegWrite_WB=0).
//  5. rst_n low while BUSY -> dmem_req=0, stall=0, all WB outputs 0 immediately; state IDLE after release.
//  6. DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 BUSY cycles req drops, bus_err_WB=1 one cycle, RegWrite_WB=0.

Source files
------------

// File: rtl/stage_mem.sv
// MEM stage and MEM/WB pipeline register: data-memory req/ack handshake with pipeline stall.
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module stage_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_mem_i,
    input  logic        flush_mem_i,
    input  logic        mem_read_mem_i,
    input  logic        mem_write_mem_i,
    input  logic        reg_write_mem_i,
    input  logic [1:0]  result_src_mem_i,
    input  logic [4:0]  rd_mem_i,
    input  logic [31:0] alu_result_mem_i,
    input  logic [31:0] write_data_mem_i,
    input  logic [31:0] pc_mem_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_mem_o,
    output logic        reg_write_wb_o,
    output logic [1:0]  result_src_wb_o,
    output logic [4:0]  rd_wb_o,
    output logic [31:0] alu_result_wb_o,
    output logic [31:0] read_data_mem_o,
    output logic [31:0] pc_wb_o,
    output logic        bus_err_wb_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic        flushed_q, flushed_d;
    logic        reg_write_q, reg_write_d;
    logic [1:0]  result_src_q, result_src_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] pc_q, pc_d;
    logic        bus_err_q, bus_err_d;

    logic mem_op;
    logic req;
    logic stall;
    logic timeout;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts BUSY cycles already spent with req held; the cycle after the last one is forced done.
    assign timeout = (state_q == StBusy) && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = '0;
        if (state_q == StBusy && stall) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign timeout               = 1'b0;
`endif

    assign mem_op = valid_mem_i & (mem_read_mem_i | mem_write_mem_i);

    // Reset gates req combinationally so an outstanding access drops the moment reset asserts.
    assign req   = rst_n & ~timeout & ((state_q == StBusy) | (mem_op & ~flush_mem_i));
    assign stall = req & ~dmem_ack_i;

    always_comb begin
        state_d      = stall ? StBusy : StIdle;
        flushed_d    = 1'b0;
        reg_write_d  = 1'b0;
        bus_err_d    = 1'b0;
        result_src_d = result_src_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        pc_d         = pc_q;
        if (stall) begin
            // A flush seen while waiting cannot abort the access; remember it for the completion.
            flushed_d = flushed_q | ((state_q == StBusy) & flush_mem_i);
        end else begin
            reg_write_d  = reg_write_mem_i & valid_mem_i & ~flush_mem_i & ~flushed_q & ~timeout;
            bus_err_d    = timeout;
            result_src_d = result_src_mem_i;
            rd_d         = rd_mem_i;
            alu_result_d = alu_result_mem_i;
            pc_d         = pc_mem_i;
            read_data_d  = (req & dmem_ack_i & ~mem_write_mem_i) ? dmem_rdata_i : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            flushed_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= 5'd0;
            alu_result_q <= 32'h0;
            read_data_q  <= 32'h0;
            pc_q         <= 32'h0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flushed_q    <= flushed_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_q         <= pc_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dmem_req_o      = req;
    assign dmem_we_o       = mem_write_mem_i;
    assign dmem_addr_o     = alu_result_mem_i;
    assign dmem_wdata_o    = write_data_mem_i;
    assign stall_mem_o     = stall;
    assign reg_write_wb_o  = reg_write_q;
    assign result_src_wb_o = result_src_q;
    assign rd_wb_o         = rd_q;
    assign alu_result_wb_o = alu_result_q;
    assign read_data_mem_o = read_data_q;
    assign pc_wb_o         = pc_q;
    assign bus_err_wb_o    = bus_err_q;

endmodule
